// File: rtl/dino_pkg.sv
// dino_pkg: shared game states, score encoding and BCD helper
package dino_pkg;
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  typedef logic [3:0] bcd_t;
  localparam int JUMP_LEN_DEF = 30;
  localparam int SCORE_W = 16;
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic c;
    bcd_t d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      d = r[4*i +: 4];
      if (c) begin
        r[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        c = (d == 4'd9);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/dino_game_ctrl_if.sv
// dino_game_ctrl_if: frame/button/pixel inputs and game state outputs
interface dino_game_ctrl_if;
  logic frame_sync, btn_jump, btn_start, video_on, dino_px, obst_px;
  logic game_status, game_over, jumping, frame_tick;
  logic [4:0] jump_time;
  logic [15:0] score, hi_score;
  modport master (
    output frame_sync, btn_jump, btn_start, video_on, dino_px, obst_px,
    input  game_status, game_over, jumping, frame_tick, jump_time, score, hi_score
  );
  modport slave (
    input  frame_sync, btn_jump, btn_start, video_on, dino_px, obst_px,
    output game_status, game_over, jumping, frame_tick, jump_time, score, hi_score
  );
endinterface

// File: rtl/dino_game_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and one-CLK press pulse
module btn_debounce #(
  parameter int DB_CYC = 250000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      {s1, s2, level, press} <= '0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      press <= 1'b0;
      if (s2 == level) cnt <= '0;
      else if (cnt == CW'(DB_CYC - 1)) begin
        level <= s2;
        press <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl: IDLE/RUN/OVER game FSM with jump arc, collision and BCD scoring
module dino_game_ctrl import dino_pkg::*; #(
  parameter int JUMP_LEN  = JUMP_LEN_DEF,
  parameter int SCORE_DIV = 6,
  parameter int DB_CYC    = 250000
) (
  input logic CLK,
  input logic RESET,
  dino_game_ctrl_if.slave bus
);
  localparam int FW = $clog2(SCORE_DIV + 1);
  localparam logic [4:0] JL = 5'(JUMP_LEN);
  state_t state, state_n;
  logic fs1, fs2, fs3, ft, jump_p, start_p, hit, wrap;
  logic jreq, jreq_n, coll, coll_n, jumping, jumping_n;
  logic [4:0] jt, jt_n;
  logic [FW-1:0] frm, frm_n;
  logic [SCORE_W-1:0] score, score_n, hi, hi_n;
  btn_debounce #(.DB_CYC(DB_CYC)) u_jump (.CLK(CLK), .RESET(RESET), .raw(bus.btn_jump), .press(jump_p));
  btn_debounce #(.DB_CYC(DB_CYC)) u_start (.CLK(CLK), .RESET(RESET), .raw(bus.btn_start), .press(start_p));
  assign hit  = bus.video_on & bus.dino_px & bus.obst_px;
  assign wrap = frm == FW'(SCORE_DIV - 1);
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      {fs1, fs2, fs3, ft, jreq, coll, jumping} <= '0;
      jt <= '0;
      frm <= '0;
      score <= '0;
      hi <= '0;
    end else begin
      fs1 <= bus.frame_sync;
      fs2 <= fs1;
      fs3 <= fs2;
      ft <= fs3 & ~fs2;
      state <= state_n;
      jreq <= jreq_n;
      coll <= coll_n;
      jumping <= jumping_n;
      jt <= jt_n;
      frm <= frm_n;
      score <= score_n;
      hi <= hi_n;
    end
  always_comb begin
    state_n = state;
    jreq_n = jreq;
    coll_n = coll;
    jumping_n = jumping;
    jt_n = jt;
    frm_n = frm;
    score_n = score;
    hi_n = hi;
    if ((state == IDLE && (start_p || jump_p)) || (state == OVER && start_p)) begin
      state_n = RUN;
      {jreq_n, coll_n, jumping_n} = '0;
      jt_n = '0;
      frm_n = '0;
      score_n = '0;
    end else if (state == RUN) begin
      jreq_n = jreq | jump_p;
      coll_n = coll | hit;
      if (ft) begin
        jreq_n = 1'b0;
        coll_n = 1'b0;
        if (coll) begin
          state_n = OVER;
          hi_n = (score > hi) ? score : hi;
        end else begin
          // an arc in progress ignores new requests until it lands
          jumping_n = jumping ? (jt != JL) : jreq;
          jt_n = jumping ? ((jt == JL) ? 5'd0 : jt + 5'd1) : (jreq ? 5'd1 : jt);
          frm_n = wrap ? '0 : frm + 1'b1;
          score_n = wrap ? bcd_inc(score) : score;
        end
      end
    end
  end
  assign bus.game_status = state == RUN;
  assign bus.game_over   = state == OVER;
  assign bus.jumping     = jumping;
  assign bus.jump_time   = jt;
  assign bus.frame_tick  = ft;
  assign bus.score       = score;
  assign bus.hi_score    = hi;
endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl: directed checks of the dino game controller with DB_CYC=4
module tb_dino_game_ctrl;
  logic clk, rst;
  int checks, passed, n_start;
  logic [15:0] bv;
  dino_game_ctrl_if bus();
  dino_game_ctrl #(.JUMP_LEN(30), .SCORE_DIV(6), .DB_CYC(4)) dut (.CLK(clk), .RESET(rst), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) if (dut.start_p) n_start++;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic frame();
    bus.frame_sync = 1'b1;
    cyc(3);
    bus.frame_sync = 1'b0;
    cyc(4);
  endtask
  task automatic press(input bit j);
    if (j) bus.btn_jump = 1'b1;
    else bus.btn_start = 1'b1;
    cyc(10);
    bus.btn_jump = 1'b0;
    bus.btn_start = 1'b0;
    cyc(8);
  endtask
  task automatic pix(input logic v);
    bus.video_on = v;
    bus.dino_px = 1'b1;
    bus.obst_px = 1'b1;
    cyc(1);
    {bus.video_on, bus.dino_px, bus.obst_px} = '0;
  endtask
  initial begin
    checks = 0;
    passed = 0;
    n_start = 0;
    rst = 1'b1;
    {bus.frame_sync, bus.btn_jump, bus.btn_start, bus.video_on, bus.dino_px, bus.obst_px} = '0;
    cyc(2);
    check("rst_status", bus.game_status, 0);
    check("rst_over", bus.game_over, 0);
    check("rst_jt", bus.jump_time, 0);
    check("rst_score", bus.score, 0);
    check("rst_hi", bus.hi_score, 0);
    check("rst_ft", bus.frame_tick, 0);
    rst = 1'b0;
    cyc(1);
    bus.frame_sync = 1'b1;
    cyc(3);
    bus.frame_sync = 1'b0;
    cyc(2);
    check("ft_early", bus.frame_tick, 0);
    cyc(1);
    check("ft_pulse", bus.frame_tick, 1);
    cyc(1);
    check("ft_single", bus.frame_tick, 0);
    check("idle_hold", bus.game_status, 0);
    bv = dino_pkg::bcd_inc(16'h9999);
    check("bcd_9999", bv, 16'h0000);
    bv = dino_pkg::bcd_inc(16'h0199);
    check("bcd_0199", bv, 16'h0200);
    bv = dino_pkg::bcd_inc(16'h0009);
    check("bcd_0009", bv, 16'h0010);
    press(0);
    check("start_pulses", n_start, 1);
    check("start_run", bus.game_status, 1);
    check("start_score", bus.score, 0);
    press(1);
    check("jreq_nojump", bus.jumping, 0);
    for (int i = 1; i <= 30; i++) begin
      frame();
      check("jt_seq", bus.jump_time, i);
      check("jumping_seq", bus.jumping, 1);
      if (i == 15) press(1);
    end
    frame();
    check("arc_end_jt", bus.jump_time, 0);
    check("arc_end_jumping", bus.jumping, 0);
    frame();
    check("no_retrigger", bus.jumping, 0);
    check("score_32", bus.score, 16'h0005);
    repeat (28) frame();
    check("score_60", bus.score, 16'h0010);
    pix(1'b0);
    frame();
    check("novid_over", bus.game_over, 0);
    check("novid_run", bus.game_status, 1);
    pix(1'b1);
    frame();
    check("coll_over", bus.game_over, 1);
    check("coll_status", bus.game_status, 0);
    check("coll_score", bus.score, 16'h0010);
    check("coll_hi", bus.hi_score, 16'h0010);
    frame();
    check("over_score_hold", bus.score, 16'h0010);
    press(1);
    check("over_jump_ignored", bus.game_over, 1);
    press(0);
    check("restart_run", bus.game_status, 1);
    check("restart_score", bus.score, 0);
    press(1);
    repeat (30) frame();
    check("arc_top_jt", bus.jump_time, 30);
    pix(1'b1);
    frame();
    check("tie_over", bus.game_over, 1);
    check("tie_jt", bus.jump_time, 30);
    check("tie_jumping", bus.jumping, 1);
    check("tie_score", bus.score, 16'h0005);
    check("tie_hi_kept", bus.hi_score, 16'h0010);
    press(0);
    check("tie_restart", bus.game_status, 1);
    check("tie_restart_jt", bus.jump_time, 0);
    check("tie_restart_jumping", bus.jumping, 0);
    check("tie_restart_score", bus.score, 0);
    press(1);
    repeat (5) frame();
    check("mid_jt", bus.jump_time, 5);
    rst = 1'b1;
    #2;
    check("arst_status", bus.game_status, 0);
    check("arst_jumping", bus.jumping, 0);
    check("arst_jt", bus.jump_time, 0);
    check("arst_hi", bus.hi_score, 0);
    check("arst_score", bus.score, 0);
    cyc(1);
    rst = 1'b0;
    cyc(2);
    check("post_rst_idle", bus.game_status | bus.game_over, 0);
    press(0);
    check("post_rst_start", bus.game_status, 1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dino_game_ctrl.md
DINO_GAME_CTRL -- requirements
Module: dino_game_ctrl

Interface
REQ-001 Parameters: JUMP_LEN, 30, frames per jump arc (jump_time range 0..JUMP_LEN).
REQ-002 Parameters: SCORE_DIV, 6, RUN frames per score increment.
REQ-003 Parameters: DB_CYC, 250000, CLK cycles a button must hold stable to be accepted.
REQ-004 CLK  in  1  system/pixel clock, all logic rising-edge.
REQ-005 RESET  in  1  reset, asynchronous, active-high.
REQ-006 frame_sync  in  1  frame refresh strobe from VGA timing; the frame boundary is its falling edge.
REQ-007 btn_jump  in  1  raw jump button, asynchronous.
REQ-008 btn_start  in  1  raw start button, asynchronous.
REQ-009 video_on  in  1  active-video qualifier for the pixel inputs.
REQ-010 dino_px  in  1  dinosaur renderer pixel, same CLK cycle as obst_px.
REQ-011 obst_px  in  1  obstacle renderer pixel.
REQ-012 game_status  out  1  1 while in RUN.
REQ-013 game_over  out  1  1 while in OVER.
REQ-014 jumping  out  1  jump arc in progress.
REQ-015 jump_time  out  5  frame index in the jump arc, drives the height computation.
REQ-016 frame_tick  out  1  one-CLK pulse per frame boundary.
REQ-017 score  out  16  4-digit BCD current score.
REQ-018 hi_score  out  16  4-digit BCD best score since RESET.

Function
REQ-019 frame_sync: 2-FF synchronised; falling edge of the synchronised value gives frame_tick, 3 CLK after the input edge.
REQ-020 Each button passes through a 2-FF synchroniser plus debounce. The debounced level updates only after DB_CYC consecutive equal samples. A debounced rising edge gives a one-CLK press pulse.
REQ-021 States IDLE, RUN, OVER. After RESET the state is IDLE.
REQ-022 IDLE: a start or jump press goes to RUN on the next CLK and clears score, jump_time, jumping and the request latches.
REQ-023 OVER: a start press goes to RUN with the same clears as REQ-022. Jump presses are ignored in OVER.
REQ-024 RUN: a jump press sets jump_req. jump_req holds until the next frame_tick and is cleared at every frame_tick.
REQ-025 At frame_tick in RUN, when not jumping and jump_req=1: set jumping=1 and jump_time=1.
REQ-026 At frame_tick in RUN, when jumping: if jump_time==JUMP_LEN, set jump_time=0 and jumping=0; otherwise increment jump_time.
REQ-027 A jump press while jumping does not retrigger or extend the arc.
REQ-028 Collision: in RUN, any CLK with video_on & dino_px & obst_px sets collide_flag. collide_flag clears at every frame_tick.
REQ-029 At frame_tick with collide_flag=1: go to OVER. jump_time and jumping freeze; score does not increment on that tick.
REQ-030 Collision and arc end on the same tick: OVER wins, and jump_time freezes at JUMP_LEN.
REQ-031 Score: a frame counter counts 0..SCORE_DIV-1 on RUN frame_ticks. On wrap, score increments in BCD, per-digit 9->0 with carry; 9999 wraps to 0000.
REQ-032 On entering OVER, if score > hi_score (unsigned BCD compare), hi_score is loaded with score on the same CLK.
REQ-033 In IDLE and OVER, frame_tick still pulses; score, jump_time and hi_score hold.

Reset
REQ-034 RESET forces state IDLE and sets all of the following to 0: game_status, game_over, jumping, jump_time, score, hi_score, jump_req, collide_flag, frame counter, debounced levels, synchronisers and frame_tick. RESET mid-jump or in OVER aborts immediately.

Structure
REQ-035 Shared package dino_pkg holds: the state enum (IDLE/RUN/OVER), JUMP_LEN default, the BCD digit type and the score width constant.
REQ-036 Sub-module btn_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated for btn_jump and btn_start.

Verification (DB_CYC=4)
REQ-037 Hold btn_start for 10 CLK in IDLE -> exactly one press pulse; game_status=1, score=0000.
REQ-038 RUN, jump press, then 31 frame_ticks -> jump_time sequence 1..30 then 0; jumping falls with the 31st tick; a second press mid-arc has no effect.
REQ-039 RUN, 60 frame_ticks with no collision -> score=0010. Preloaded score 9999 plus 6 ticks -> 0000.
REQ-040 dino_px=obst_px=video_on=1 for one CLK in RUN -> game_over=1 at the next frame_tick and hi_score=score. With video_on=0 -> no transition.
REQ-041 Collision and jump_time==30 on the same tick -> OVER with jump_time=30 and jumping=1 held. A start press then -> RUN with jump_time=0 and score=0000.
REQ-042 RESET asserted mid-jump -> all outputs 0 asynchronously; state IDLE after release.
